// File: rtl/frame_peak_ctrl_if.sv
// Sample stream and peak report port of the frame peak controller.
// master drives samples and report-ready; slave is the controller itself.
interface frame_peak_ctrl_if #(
  parameter int W    = 16,
  parameter int SH_W = 4
) ();
  logic [W-1:0]    x;
  logic            x_v;
  logic            x_rdy;
  logic [W-1:0]    pk;
  logic [SH_W-1:0] pk_shift;
  logic            pk_v;
  logic            pk_rdy;

  modport master (
    output x, x_v, pk_rdy,
    input  x_rdy, pk, pk_shift, pk_v
  );

  modport slave (
    input  x, x_v, pk_rdy,
    output x_rdy, pk, pk_shift, pk_v
  );
endinterface

// File: rtl/frame_peak_ctrl.sv
// Frame sequencer for the LPC peak detector: splits accepted samples into frames and reports each frame's absolute peak.
// Define FRAME_PEAK_SHIFT_EN to build the leading-zero normalisation shift on pk_shift; otherwise pk_shift is tied to 0.
module frame_peak_ctrl #(
  parameter int W         = 16,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 8,
  parameter int SH_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_cont,
  input  logic               i_abort,
  output logic               o_busy,
  frame_peak_ctrl_if.slave   io_stream
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     MOST_POS = {1'b0, {(W-1){1'b1}}};

  stateT            r_state;
  stateT            w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     w_accNext;
  logic [W-1:0]     r_pk;
  logic [W-1:0]     w_pkNext;
  logic             r_pkV;
  logic             w_pkVNext;
  logic             w_loadPk;

  logic             w_xRdy;
  logic             w_accept;
  logic             w_handshake;
  logic [W-1:0]     w_mag;
  logic [W-1:0]     w_peak;

  // Abort gates x_rdy so an aborted cycle can never count a sample.
  assign w_xRdy      = (r_state == ACCUM) && !i_abort;
  assign w_accept    = w_xRdy && io_stream.x_v;
  assign w_handshake = r_pkV && io_stream.pk_rdy;

  // Saturating magnitude: the most negative code has no positive twin.
  always_comb begin
    w_mag = io_stream.x;
    if (io_stream.x == MOST_NEG) begin
      w_mag = MOST_POS;
    end else if (io_stream.x[W-1]) begin
      w_mag = ~io_stream.x + 1'b1;
    end
  end

  assign w_peak = (w_mag > r_acc) ? w_mag : r_acc;

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_accNext   = r_acc;
    w_pkNext    = r_pk;
    w_pkVNext   = r_pkV;
    w_loadPk    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_stateNext = ACCUM;
          w_cntNext   = '0;
          w_accNext   = '0;
        end
      end
      ACCUM: begin
        if (i_abort) begin
          w_stateNext = IDLE;
          w_pkVNext   = 1'b0;
        end else if (w_accept) begin
          w_accNext = w_peak;
          w_cntNext = r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_stateNext = REPORT;
            w_pkNext    = w_peak;
            w_pkVNext   = 1'b1;
            w_loadPk    = 1'b1;
          end
        end
      end
      REPORT: begin
        if (i_abort) begin
          w_stateNext = IDLE;
          w_pkVNext   = 1'b0;
        end else if (w_handshake) begin
          w_pkVNext = 1'b0;
          if (i_cont) begin
            w_stateNext = ACCUM;
            w_cntNext   = '0;
            w_accNext   = '0;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_pkVNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_pk    <= '0;
      r_pkV   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_acc   <= w_accNext;
      r_pk    <= w_pkNext;
      r_pkV   <= w_pkVNext;
    end
  end

`ifdef FRAME_PEAK_SHIFT_EN
  logic [SH_W-1:0] r_pkShift;

  // Zeros between bit W-2 and the MSB of v; an all-zero value gives W-1.
  function automatic logic [SH_W-1:0] leadZeros(input logic [W-1:0] v);
    leadZeros = SH_W'(W - 1);
    for (int i = 0; i < W - 1; i++) begin
      if (v[i]) begin
        leadZeros = SH_W'(W - 2 - i);
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkShift <= '0;
    end else if (w_loadPk) begin
      r_pkShift <= leadZeros(w_pkNext);
    end
  end

  assign io_stream.pk_shift = r_pkShift;
`else
  assign io_stream.pk_shift = {SH_W{1'b0}};
`endif

  assign io_stream.x_rdy = w_xRdy;
  assign io_stream.pk    = r_pk;
  assign io_stream.pk_v  = r_pkV;
  assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_frame_peak_ctrl.sv
// Self-checking bench for frame_peak_ctrl (FRAME_LEN=4): directed scenarios plus random traffic against a frame-level model.
module tb_frame_peak_ctrl;
  localparam int W     = 16;
  localparam int FL    = 4;
  localparam int CNT_W = 8;
  localparam int SH_W  = 4;
`ifdef FRAME_PEAK_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_COLL = 1;
  localparam int PH_REP  = 2;

  logic clk;
  logic rst;
  logic start;
  logic cont;
  logic abort;
  logic busy;

  frame_peak_ctrl_if #(.W(W), .SH_W(SH_W)) stream ();

  frame_peak_ctrl #(
    .W(W), .FRAME_LEN(FL), .CNT_W(CNT_W), .SH_W(SH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_cont(cont),
    .i_abort(abort),
    .o_busy(busy),
    .io_stream(stream)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  int mPhase = PH_IDLE;
  int mSamples[$];
  int mPk    = 0;
  int mShift = 0;
  bit mPkV   = 1'b0;

  function automatic int expShift(input int p);
    if (!SHIFT_ON) return 0;
    return (W - 1) - $clog2(p + 1);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit c, input bit a,
                               input bit xv, input logic [W-1:0] xd, input bit pr);
    rst           = r;
    start         = s;
    cont          = c;
    abort         = a;
    stream.x_v    = xv;
    stream.x      = xd;
    stream.pk_rdy = pr;
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: collect accepted magnitudes, report the max after FL of them.
  always @(posedge clk) begin
    int xi;
    int m;
    int best;
    if (rst) begin
      mPhase = PH_IDLE;
      mPk    = 0;
      mShift = 0;
      mPkV   = 1'b0;
      mSamples.delete();
    end else begin
      case (mPhase)
        PH_IDLE: begin
          if (start) begin
            mPhase = PH_COLL;
            mSamples.delete();
          end
        end
        PH_COLL: begin
          if (abort) begin
            mPhase = PH_IDLE;
          end else if (stream.x_v) begin
            xi = int'($signed(stream.x));
            m  = (xi < 0) ? -xi : xi;
            if (m > 32767) m = 32767;
            mSamples.push_back(m);
            if (mSamples.size() == FL) begin
              best = 0;
              foreach (mSamples[i]) if (mSamples[i] > best) best = mSamples[i];
              mPk    = best;
              mShift = expShift(best);
              mPkV   = 1'b1;
              mPhase = PH_REP;
            end
          end
        end
        default: begin
          if (abort) begin
            mPkV   = 1'b0;
            mPhase = PH_IDLE;
          end else if (stream.pk_rdy) begin
            mPkV = 1'b0;
            if (cont) begin
              mPhase = PH_COLL;
              mSamples.delete();
            end else begin
              mPhase = PH_IDLE;
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("x_rdy", int'(stream.x_rdy), int'((mPhase == PH_COLL) && !abort));
      checkOutput("busy", int'(busy), int'(mPhase != PH_IDLE));
      checkOutput("pk_v", int'(stream.pk_v), int'(mPkV));
      checkOutput("pk", int'(stream.pk), mPk);
      checkOutput("pk_shift", int'(stream.pk_shift), mShift);
    end
  end

  initial begin
    logic [W-1:0] rx;
    int sel;

    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    checkOutput("reset_pk", int'(stream.pk), 0);
    checkOutput("reset_pk_v", int'(stream.pk_v), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_shift", int'(stream.pk_shift), 0);

    // Basic frame 3,-7,5,2 with single-cycle report.
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd3, 0);
    applyStimulus(0, 0, 0, 0, 1, -16'sd7, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd5, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd2, 0);
    checkOutput("s1_pk_v", int'(stream.pk_v), 1);
    checkOutput("s1_pk", int'(stream.pk), 7);
    checkOutput("s1_shift", int'(stream.pk_shift), SHIFT_ON ? 12 : 0);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    checkOutput("s1_idle_busy", int'(busy), 0);

    // Most negative sample saturates; continuous mode into an all-zero frame.
    applyStimulus(0, 1, 1, 0, 0, '0, 1);
    applyStimulus(0, 0, 1, 0, 1, 16'd100, 1);
    applyStimulus(0, 0, 1, 0, 1, 16'h8000, 1);
    applyStimulus(0, 0, 1, 0, 1, 16'd5, 1);
    applyStimulus(0, 0, 1, 0, 1, 16'd1, 1);
    checkOutput("s2_pk", int'(stream.pk), 32767);
    checkOutput("s2_shift", int'(stream.pk_shift), 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1, 16'd0, 1);
    checkOutput("s2_zero_pk", int'(stream.pk), 0);
    checkOutput("s2_zero_shift", int'(stream.pk_shift), SHIFT_ON ? 15 : 0);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);

    // Gapped samples, report held for 5 cycles.
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, (i % 2) == 0, 16'(i * 300), 0);
    checkOutput("s3_pk_v", int'(stream.pk_v), 1);
    checkOutput("s3_pk", int'(stream.pk), 1800);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 16'd9999, 0);
    checkOutput("s3_pk_stable", int'(stream.pk), 1800);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);

    // Abort with the third sample, then a fresh frame.
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd4000, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd4001, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'd4002, 0);
    checkOutput("s4_busy", int'(busy), 0);
    checkOutput("s4_pk_kept", int'(stream.pk), 1800);
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd9, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd1, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd1, 0);
    checkOutput("s4_no_early_pk_v", int'(stream.pk_v), 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd1, 0);
    checkOutput("s4_pk", int'(stream.pk), 9);

    // Reset while a report is pending, with start and a sample in the same cycle.
    applyStimulus(1, 1, 0, 0, 1, 16'd77, 0);
    checkOutput("s5_pk", int'(stream.pk), 0);
    checkOutput("s5_pk_v", int'(stream.pk_v), 0);
    checkOutput("s5_busy", int'(busy), 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd77, 1);
    checkOutput("s5_still_idle", int'(busy), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       rx = 16'h8000;
        1:       rx = 16'h7FFF;
        2:       rx = 16'h0000;
        3:       rx = 16'(($urandom_range(0, 31)) - 16);
        default: rx = 16'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1) == 1, ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 2) != 0), rx, $urandom_range(0, 1) == 1);
    end

    applyStimulus(0, 0, 0, 0, 0, '0, 0);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
